image_write: RTL and testbench
==============================

IMAGE_WRITE -- requirements
Module: image_write

Interface
REQ-001 WIDTH, 768, image width in pixels; even; row length in pixel pairs is WIDTH/2.
REQ-002 HEIGHT, 512, image height in rows.
REQ-003 FIFO_DEPTH, 8, pixel-pair buffer entries; power of two, at least 4.
REQ-004 HCLK  in  1  single clock; all logic on rising edge.
REQ-005 HRESETn  in  1  reset; synchronous, active-low.
REQ-006 VSYNC  in  1  frame start; its rising edge begins a frame.
REQ-007 HSYNC  in  1  qualifies one pixel pair per cycle.
REQ-008 DATA_R0/G0/B0, DATA_R1/G1/B1  in  8 each  even (0) and odd (1) pixel of the pair.
REQ-009 wr_valid  out  1  output word valid.
REQ-010 wr_ready  in  1  sink accepts a word; a transfer occurs when wr_valid and wr_ready are both high.
REQ-011 wr_addr  out  18  6-byte word address in the BMP image.
REQ-012 wr_data  out  48  six bytes; byte k is at bits [8k+7:8k].
REQ-013 write_done  out  1  whole frame written.
REQ-014 overflow  out  1  sticky flag: a pair was dropped.

Function
REQ-015 FSM states are IDLE, HEADER, DATA and DONE; a VSYNC rising edge in any state moves the FSM to HEADER and clears the row, col, word count, FIFO, write_done and overflow.
REQ-016 HEADER issues 9 words at addresses 0-8, then moves to DATA; pairs arriving during HEADER are buffered.
REQ-017 HEADER bytes 0-53 form a standard 54-byte BMP header, all fields little-endian:
- "BM"; file size = 54 + WIDTH*HEIGHT*3; reserved 0; data offset 54.
- DIB size 40; WIDTH; HEIGHT; planes 1; bpp 24; compression 0.
- image size = WIDTH*HEIGHT*3; all remaining fields 0.
REQ-018 Each HSYNC-high cycle in HEADER or DATA pushes one entry {address, data} into the FIFO; HSYNC is ignored in IDLE and DONE.
REQ-019 Pixel data byte order is B0,G0,R0,B1,G1,R1 as bytes 0-5.
REQ-020 Pixel address = OFS + (WIDTH/2)*(HEIGHT-1-row) + col/2, where OFS is 9 (or 0, REQ-031); rows are stored bottom-up.
REQ-021 col advances by 2 per pair; at col = WIDTH-2, col returns to 0 and row increments.
REQ-022 A pair arriving while the FIFO is full is dropped, sets overflow, and still advances row/col.
REQ-023 In DATA, the FIFO head drives wr_valid/wr_addr/wr_data.
REQ-024 wr_addr and wr_data hold stable while wr_valid=1 and wr_ready=0.
REQ-025 A push and a pop in the same cycle on a full FIFO both succeed; no drop occurs.
REQ-026 After WIDTH*HEIGHT/2 pixel words are popped or dropped, the FSM enters DONE; write_done=1 until the next VSYNC rising edge or reset.
REQ-027 Latency from pair input to wr_valid is 1 cycle when the FIFO is empty and the FSM is in DATA.

Reset
REQ-028 On HRESETn=0 at a clock edge: FSM to IDLE; FIFO emptied; row, col and counts set to 0; wr_valid=0, wr_addr=0, wr_data=0, write_done=0, overflow=0.
REQ-029 Reset mid-frame abandons the frame; no further word is issued until the next VSYNC rising edge.

Configuration
REQ-030 Macro IMAGE_WRITE_HEADER_EN defined: HEADER behaves as in REQ-016/017 and OFS=9.
REQ-031 Macro IMAGE_WRITE_HEADER_EN undefined: HEADER lasts 1 cycle with no words issued, OFS=0, and no header logic is present.

Structure
REQ-032 Shared package image_pkg holds:
- FSM state encoding;
- the 54-byte header field constants;
- a header-word function of (index, WIDTH, HEIGHT).
REQ-033 The FIFO is a sub-module named image_write_fifo, parameterised by depth and entry width (66 bits).

Verification
REQ-034 Defaults, macro defined, wr_ready=1, VSYNC rise -> word 0 at addr 0 = 48'h0012_0036_4D42; words 1-8 follow at addr 1-8.
REQ-035 First pair R0=0x11,G0=0x22,B0=0x33,R1=0x44,G1=0x55,B1=0x66 -> addr 196233, data 48'h4455_6611_2233.
REQ-036 Full frame, 384-cycle HSYNC bursts separated by 160-cycle gaps -> last word at addr 392; write_done=1; overflow=0; 196608 pixel words total.
REQ-037 wr_ready=0 for 20 cycles during a burst -> 8 pairs buffered, 12 dropped, overflow=1; the held word stays stable.
REQ-038 HRESETn=0 mid-row, then VSYNC rise -> outputs at reset values; new frame restarts at addr 0.
REQ-039 Macro undefined -> first word at addr 196224; no header words issued.

Source files
------------

// File: rtl/image_write_pkg.sv
// Shared FSM encoding, BMP header field constants and header-word builder for image_write.
// The header content is only consumed when IMAGE_WRITE_HEADER_EN is defined.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } image_state_t;

    localparam int          HEADER_BYTES    = 54;
    localparam int          HEADER_WORDS    = 9;
    localparam logic [15:0] BMP_MAGIC       = 16'h4D42;
    localparam logic [31:0] BMP_DATA_OFFSET = 32'd54;
    localparam logic [31:0] BMP_DIB_SIZE    = 32'd40;
    localparam logic [15:0] BMP_PLANES      = 16'd1;
    localparam logic [15:0] BMP_BPP         = 16'd24;
    localparam logic [31:0] BMP_COMPRESSION = 32'd0;

    // Lays out the 54 header bytes little-endian and returns the 6-byte word at index.
    function automatic logic [47:0] header_word(input logic [3:0] index, input int width, input int height);
        logic [HEADER_BYTES*8-1:0] hdr;
        logic [31:0]               image_size;
        image_size     = 32'(width * height * 3);
        hdr            = '0;
        hdr[0   +: 16] = BMP_MAGIC;
        hdr[16  +: 32] = image_size + BMP_DATA_OFFSET;
        hdr[80  +: 32] = BMP_DATA_OFFSET;
        hdr[112 +: 32] = BMP_DIB_SIZE;
        hdr[144 +: 32] = 32'(width);
        hdr[176 +: 32] = 32'(height);
        hdr[208 +: 16] = BMP_PLANES;
        hdr[224 +: 16] = BMP_BPP;
        hdr[240 +: 32] = BMP_COMPRESSION;
        hdr[272 +: 32] = image_size;
        if (index < 4'(HEADER_WORDS)) begin
            return hdr[index*48 +: 48];
        end
        return '0;
    endfunction

endpackage

// File: rtl/image_write_fifo.sv
// Pixel-pair buffer for image_write: synchronous FIFO with clear, accepting a push
// on a full FIFO when a pop happens in the same cycle.
module image_write_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 66
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               clear,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge HCLK) begin
        if (!HRESETn || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: only entries below count are ever presented.
    always_ff @(posedge HCLK) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/image_write.sv
// BMP frame writer: emits the 54-byte header as 6-byte words, then pixel pairs bottom-up.
// Define IMAGE_WRITE_HEADER_EN to emit the header at addresses 0-8 (pixel base 9).
module image_write
    import image_pkg::*;
#(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    input  logic        wr_ready,
    output logic        wr_valid,
    output logic [17:0] wr_addr,
    output logic [47:0] wr_data,
    output logic        write_done,
    output logic        overflow
);
    localparam int HALF_W      = WIDTH / 2;
    localparam int TOTAL_WORDS = WIDTH * HEIGHT / 2;
    localparam int COL_W       = $clog2(WIDTH);
    localparam int ROW_W       = $clog2(HEIGHT + 1);
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1);
    localparam int ENTRY_W     = 66;
`ifdef IMAGE_WRITE_HEADER_EN
    localparam logic [17:0] OFS = 18'd9;
`else
    localparam logic [17:0] OFS = 18'd0;
`endif

    image_state_t       state;
    image_state_t       next_state;
    logic               vsync_d;
    logic               vsync_rise;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   word_cnt_next;
    logic               pair_in;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop;
    logic               header_done;
    logic [17:0]        pix_addr;
    logic [47:0]        pair_data;
    logic [ENTRY_W-1:0] fifo_head;

    assign vsync_rise    = VSYNC && !vsync_d;
    assign pair_in       = HSYNC && (state == HEADER || state == DATA) && !vsync_rise;
    assign fifo_pop      = (state == DATA) && !fifo_empty && wr_ready;
    assign drop          = pair_in && fifo_full && !fifo_pop;
    assign word_cnt_next = word_cnt + CNT_W'(fifo_pop) + CNT_W'(drop);
    assign write_done    = (state == DONE);
    assign pair_data     = {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
    assign pix_addr      = OFS + 18'(HALF_W) * (18'(HEIGHT - 1) - 18'(row)) + 18'(col >> 1);

`ifdef IMAGE_WRITE_HEADER_EN
    logic [3:0] hdr_idx;
    logic       hdr_last;

    assign hdr_last    = (hdr_idx == 4'(HEADER_WORDS - 1));
    assign header_done = (state == HEADER) && wr_ready && hdr_last;

    always_ff @(posedge HCLK) begin
        if (!HRESETn || vsync_rise) begin
            hdr_idx <= '0;
        end else if (state == HEADER && wr_ready && !hdr_last) begin
            hdr_idx <= hdr_idx + 1'b1;
        end
    end
`else
    assign header_done = 1'b1;
`endif

    image_write_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .clear     (vsync_rise),
        .push      (pair_in),
        .push_data ({pix_addr, pair_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Reset to 1 so a VSYNC already high when reset releases is not taken as a frame start.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) vsync_d <= 1'b1;
        else          vsync_d <= VSYNC;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            HEADER:  if (header_done) next_state = DATA;
            DATA:    if (word_cnt_next == CNT_W'(TOTAL_WORDS)) next_state = DONE;
            default: next_state = state;
        endcase
        if (vsync_rise) next_state = HEADER;
    end

    // Dropped pairs still move the raster position and count toward frame completion.
    always_ff @(posedge HCLK) begin
        if (!HRESETn || vsync_rise) begin
            col      <= '0;
            row      <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (pair_in) begin
                if (col == COL_W'(WIDTH - 2)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + COL_W'(2);
                end
            end
            word_cnt <= word_cnt_next;
            if (drop) overflow <= 1'b1;
        end
    end

    always_comb begin
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        case (state)
`ifdef IMAGE_WRITE_HEADER_EN
            HEADER: begin
                wr_valid = 1'b1;
                wr_addr  = 18'(hdr_idx);
                wr_data  = header_word(hdr_idx, WIDTH, HEIGHT);
            end
`endif
            DATA: begin
                if (!fifo_empty) begin
                    wr_valid           = 1'b1;
                    {wr_addr, wr_data} = fifo_head;
                end
            end
            default: wr_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_image_write.sv
// Scoreboard bench for image_write: a small-frame instance covers whole frames, stalls and
// reset; a default-size instance covers the absolute header and first-pixel values.
`timescale 1ns/1ps
module tb_image_write;

    localparam int SW     = 16;
    localparam int SH     = 6;
    localparam int SDEPTH = 8;
    localparam int HALF   = SW / 2;
    localparam int NPAIRS = SW * SH / 2;
`ifdef IMAGE_WRITE_HEADER_EN
    localparam int OFS    = 9;
    localparam int NHDR   = 9;
`else
    localparam int OFS    = 0;
    localparam int NHDR   = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        VSYNC = 1'b0;
    logic        HSYNC = 1'b0;
    logic        wr_ready = 1'b0;
    logic [7:0]  r0 = 8'd0, g0 = 8'd0, b0 = 8'd0, r1 = 8'd0, g1 = 8'd0, b1 = 8'd0;
    logic        wr_valid, write_done, overflow;
    logic [17:0] wr_addr;
    logic [47:0] wr_data;
    logic        d_valid, d_done, d_ovf;
    logic [17:0] d_addr;
    logic [47:0] d_data;

    logic [65:0] exp_q[$];
    logic [65:0] def_words[$];
    int          checks = 0;
    int          errors = 0;
    int          occ = 0;
    int          pair_idx = 0;
    int          frame_words = 0;
    logic [17:0] last_addr = '0;
    bit          exp_overflow = 0;
    bit          model_active = 0;
    bit          def_capture = 1;

    always #5 HCLK = ~HCLK;

    image_write #(.WIDTH(SW), .HEIGHT(SH), .FIFO_DEPTH(SDEPTH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .write_done(write_done), .overflow(overflow)
    );

    image_write dut_def (
        .HCLK(HCLK), .HRESETn(HRESETn), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0), .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
        .wr_ready(wr_ready), .wr_valid(d_valid), .wr_addr(d_addr), .wr_data(d_data),
        .write_done(d_done), .overflow(d_ovf)
    );

    // Reference BMP header built byte by byte from the field list.
    function automatic logic [47:0] ref_header(input int idx, input int w, input int h);
        logic [7:0]  b[54];
        logic [47:0] word;
        int          fsize;
        int          isize;
        isize = w * h * 3;
        fsize = 54 + isize;
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h42;
        b[1] = 8'h4D;
        for (int k = 0; k < 4; k++) begin
            b[2 + k]  = 8'(fsize >> (8 * k));
            b[10 + k] = 8'(54 >> (8 * k));
            b[14 + k] = 8'(40 >> (8 * k));
            b[18 + k] = 8'(w >> (8 * k));
            b[22 + k] = 8'(h >> (8 * k));
            b[34 + k] = 8'(isize >> (8 * k));
        end
        b[26] = 8'd1;
        b[28] = 8'd24;
        for (int k = 0; k < 6; k++) word[8*k +: 8] = b[6*idx + k];
        return word;
    endfunction

    // Pair p of the frame lands at row p/HALF, stored bottom-up.
    function automatic logic [17:0] exp_addr(input int p);
        return 18'(OFS + HALF * (SH - 1 - p / HALF) + p % HALF);
    endfunction

    task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus; the buffer model decides whether the pair is kept or dropped.
    task automatic applyStimulus(input logic hs, input logic [47:0] px, input logic rdy);
        bit pop;
        HSYNC    = hs;
        wr_ready = rdy;
        b0 = px[7:0];   g0 = px[15:8];  r0 = px[23:16];
        b1 = px[31:24]; g1 = px[39:32]; r1 = px[47:40];
        pop = rdy && (occ > 0);
        if (hs && model_active) begin
            if (occ < SDEPTH || pop) begin
                exp_q.push_back({exp_addr(pair_idx), px});
                occ++;
            end else begin
                exp_overflow = 1;
            end
            pair_idx++;
        end
        if (pop) occ--;
        @(posedge HCLK);
        #1;
    endtask

    task automatic startFrame();
        exp_q.delete();
        occ          = 0;
        pair_idx     = 0;
        frame_words  = 0;
        exp_overflow = 0;
        model_active = 1;
`ifdef IMAGE_WRITE_HEADER_EN
        for (int i = 0; i < 9; i++) exp_q.push_back({18'(i), ref_header(i, SW, SH)});
`endif
        VSYNC = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        VSYNC = 1'b0;
        waitDrain("header_drain");
        repeat (2) applyStimulus(1'b0, '0, 1'b1);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput(name, 66'(exp_q.size()), 66'd0);
    endtask

    task automatic sendPairs(input int n, input int ready_pct);
        for (int i = 0; i < n; i++) begin
            if (pair_idx > 0 && pair_idx % HALF == 0) begin
                repeat ($urandom_range(2, 6)) applyStimulus(1'b0, '0, $urandom_range(99) < ready_pct);
            end
            applyStimulus(1'b1, {16'($urandom), 32'($urandom)}, $urandom_range(99) < ready_pct);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 66'(wr_valid), 66'd0);
        checkOutput({tag, "_addr"}, 66'(wr_addr), 66'd0);
        checkOutput({tag, "_data"}, 66'(wr_data), 66'd0);
        checkOutput({tag, "_done"}, 66'(write_done), 66'd0);
        checkOutput({tag, "_overflow"}, 66'(overflow), 66'd0);
        checkOutput({tag, "_def_valid"}, 66'(d_valid), 66'd0);
    endtask

    // Monitor: every transfer is compared with the scoreboard; stalled words must hold.
    initial begin : monitor
        bit          held;
        logic [65:0] held_word;
        logic [65:0] exp;
        held = 0;
        held_word = '0;
        forever begin
            @(negedge HCLK);
            if (wr_valid) begin
                if (held) checkOutput("stall_hold", {wr_addr, wr_data}, held_word);
                if (wr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got %0h expected none", {wr_addr, wr_data});
                    end else begin
                        exp = exp_q.pop_front();
                        checkOutput("word", {wr_addr, wr_data}, exp);
                    end
                    frame_words++;
                    last_addr = wr_addr;
                    held = 0;
                end else begin
                    held      = 1;
                    held_word = {wr_addr, wr_data};
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin : def_monitor
        forever begin
            @(negedge HCLK);
            if (def_capture && d_valid && wr_ready && def_words.size() < 16) def_words.push_back({d_addr, d_data});
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        checkResetState("reset");
        HRESETn = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, 1'b1);

        // Frame A: sink always ready, fixed first pair
        startFrame();
        applyStimulus(1'b1, 48'h4455_6611_2233, 1'b1);
        checkOutput("first_latency_valid", 66'(wr_valid), 66'd1);
        checkOutput("first_pair_addr", 66'(wr_addr), 66'(exp_addr(0)));
        checkOutput("done_midframe", 66'(write_done), 66'd0);
        sendPairs(NPAIRS - 1, 100);
        waitDrain("frameA_drain");
        repeat (2) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("frameA_done", 66'(write_done), 66'd1);
        checkOutput("frameA_overflow", 66'(overflow), 66'd0);
        checkOutput("frameA_pixel_words", 66'(frame_words - NHDR), 66'(NPAIRS));
        checkOutput("frameA_last_addr", 66'(last_addr), 66'(OFS + HALF - 1));

        def_capture = 0;
`ifdef IMAGE_WRITE_HEADER_EN
        checkOutput("def_word_count", 66'(def_words.size() >= 10), 66'd1);
        if (def_words.size() >= 10) begin
            checkOutput("def_header_word0", def_words[0], {18'd0, 48'h0012_0036_4D42});
            for (int i = 1; i < 9; i++) checkOutput("def_header_word", def_words[i], {18'(i), ref_header(i, 768, 512)});
            checkOutput("def_first_pixel", def_words[9], {18'd196233, 48'h4455_6611_2233});
        end
`else
        checkOutput("def_word_count", 66'(def_words.size() >= 1), 66'd1);
        if (def_words.size() >= 1) checkOutput("def_first_pixel", def_words[0], {18'd196224, 48'h4455_6611_2233});
`endif

        // Frame B: 20-cycle sink stall during a burst starting from an empty buffer
        startFrame();
        sendPairs(10, 100);
        waitDrain("frameB_predrain");
        checkOutput("pre_stall_overflow", 66'(overflow), 66'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, {16'($urandom), 32'($urandom)}, 1'b0);
        checkOutput("stall_overflow", 66'(overflow), 66'd1);
        checkOutput("stall_valid", 66'(wr_valid), 66'd1);
        sendPairs(NPAIRS - 30, 75);
        waitDrain("frameB_drain");
        repeat (2) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("frameB_done", 66'(write_done), 66'd1);
        checkOutput("frameB_overflow", 66'(overflow), 66'd1);

        // Frame C: reset mid-row abandons the frame
        startFrame();
        sendPairs(5, 100);
        HRESETn      = 1'b0;
        wr_ready     = 1'b0;
        HSYNC        = 1'b0;
        exp_q.delete();
        occ          = 0;
        model_active = 0;
        repeat (2) @(posedge HCLK);
        #1;
        checkResetState("midreset");
        HRESETn = 1'b1;
        repeat (4) applyStimulus(1'b1, {16'($urandom), 32'($urandom)}, 1'b1);
        checkOutput("idle_after_reset_valid", 66'(wr_valid), 66'd0);

        // Frame D: random sink readiness, restarts from address 0
        startFrame();
        sendPairs(NPAIRS, 60);
        waitDrain("frameD_drain");
        repeat (2) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("frameD_done", 66'(write_done), 66'd1);
        checkOutput("frameD_overflow", 66'(overflow), 66'(exp_overflow));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
